uart_transmitter: RTL
=====================

# uart_transmitter

Serializes one byte at a time onto the UART TX line using 8N1 framing (optionally 8E1). It sits on the processor's memory-mapped I/O path. The CPU side offers bytes through a ready/valid handshake. The serial side drives the off-chip TX pin at a fixed baud rate derived from the system clock.

## Interface

- CLOCK_FREQ, default 33_000_000: system clock frequency in Hz.
- BAUD_RATE, default 115_200: line rate in bits/s.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  byte to transmit; sampled only on an accepted handshake.
- data_in_valid  input  1  producer has a byte on data_in.
- data_in_ready  output  1  transmitter can accept a byte this cycle.
- serial_out  output  1  TX line; idle/mark = 1.

## Operation

- Bit period S = CLOCK_FREQ / BAUD_RATE, using integer division (truncating).
  - The cycle counter is $clog2(S) bits wide.
  - S ≥ 2 is required; enforce it with an elaboration-time check.
- Handshake: a byte is accepted at a rising edge where data_in_valid && data_in_ready.
  - data_in is latched into a shift register at that edge.
  - data_in_valid while data_in_ready=0 is ignored; there is no pending or queued request.
  - data_in may change freely after acceptance.
- data_in_ready = (state == IDLE) && !reset. This is the only combinational output.
- State machine:
  - IDLE: serial_out=1. On handshake → START.
  - START: serial_out=0 for S cycles → DATA, bit index 0.
  - DATA: serial_out = shift register bit 0 for S cycles, then shift right.
    - After bit 7: → PARITY if enabled, else → STOP.
  - PARITY: serial_out = ^byte (even parity) for S cycles → STOP.
  - STOP: serial_out=1 for S cycles → IDLE.
- Bit order: LSB first.
- serial_out is a registered output, driven directly from a flop, so the TX pin never glitches.
- Reset:
  - Values: state=IDLE, serial_out=1, bit index=0, cycle counter=0; data_in_ready=0 while reset is high.
  - A reset mid-frame aborts the frame. serial_out=1 from the first edge with reset high, and the partial byte is discarded.
  - The first edge after reset deasserts can accept a byte.

## Timing

- Handshake at edge t: serial_out=0 during cycles t+1 … t+S.
- Data bit k occupies cycles t+(k+1)S+1 … t+(k+2)S.
- Stop bit occupies t+9S+1 … t+10S (shifted by +S with parity).
- data_in_ready rises at cycle t+10S+1 (t+11S+1 with parity).
  - Back-to-back transfers therefore have exactly one idle-high cycle between a stop bit and the next start bit.
- Frame length: 10S cycles (11S with parity).
- Counter wrap: the counter counts 0 … S-1. The state/bit advance happens on the edge where the counter is S-1, and the counter returns to 0 on that edge.

## Configuration

- UART_TX_PARITY_EN
  - Defined: PARITY state is compiled in. An even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit. The frame is 11 bits.
  - Undefined: the PARITY state and its logic are absent, DATA goes directly to STOP, and the frame is 10 bits (8N1).
  - The receiver must be built with the same setting.

## Structure

- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants UART_START_BIT=1'b0, UART_STOP_BIT=1'b1, UART_IDLE_LEVEL=1'b1, UART_DATA_BITS=8;
  - function symbol_cycles(CLOCK_FREQ, BAUD_RATE).
- One sub-module, uart_baud_counter: a parameterized 0 … S-1 counter.
  - It has a clear input (asserted on handshake and on reset).
  - It outputs tick, a one-cycle pulse when the count equals S-1.
  - The FSM advances only on tick.

## Test plan

Use CLOCK_FREQ=1000, BAUD_RATE=100, so S=10.

1. Reset values:
   - Stimulus: hold reset 3 cycles, then release.
   - Required: serial_out=1 throughout; data_in_ready=0 during reset and 1 on the first cycle after release.
2. Single byte:
   - Stimulus: send 0x55.
   - Required: serial_out, sampled mid-bit, reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
   - Each level lasts exactly 10 cycles, and data_in_ready is low for exactly 100 cycles.
3. Back-to-back:
   - Stimulus: hold valid high with 0xA3 then 0x0F.
   - Required: the second start bit begins 101 cycles after the first.
   - Exactly one idle-high cycle separates the frames, and the decoded bytes match.
4. Ignored request:
   - Stimulus: pulse valid with 0xFF while busy on 0x00.
   - Required: only 0x00 is sent; no second frame follows.
   - data_in changing after acceptance does not alter the frame.
5. Mid-frame reset:
   - Stimulus: assert reset at cycle 45 of a 0x00 frame.
   - Required: serial_out=1 from the next edge and stays high.
   - The next byte after release is sent with a correct full frame.
6. With UART_TX_PARITY_EN defined:
   - 0x55 → parity bit 0 and a 110-cycle frame.
   - 0x07 → parity bit 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, line levels and bit-period helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   UART_DATA_BITS  = 8;

  // Clock cycles per line symbol, truncating; a non-positive rate yields 0 so the
  // elaboration check in the transmitter rejects it.
  function automatic int symbol_cycles(input int clock_freq, input int baud_rate);
    if (baud_rate <= 0) return 0;
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter 0..SYMBOL_CYCLES-1; tick pulses for one cycle on the last count.
// Zero latency: tick is combinational from the count; clear has priority over enable.
module uart_baud_counter #(
  parameter int SYMBOL_CYCLES = 10
) (
  input  logic clk,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (SYMBOL_CYCLES > 2) ? $clog2(SYMBOL_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(SYMBOL_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN); ready/valid input, one byte in flight.
// Start bit follows the handshake edge; busy (ready low) for the whole frame, excess valids ignored.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 33_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_CYCLES = symbol_cycles(CLOCK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  if (SYMBOL_CYCLES < 2) begin : g_rate_check
    $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end

  uart_state_t state;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic        accept;
  logic        tick;
  logic        count_clear;
  logic        count_en;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit;
`endif

  assign data_in_ready = (state == IDLE) && !reset;
  assign accept        = data_in_valid && data_in_ready;
  assign count_clear   = reset || accept;
  assign count_en      = (state != IDLE);

  uart_baud_counter #(
    .SYMBOL_CYCLES(SYMBOL_CYCLES)
  ) u_baud_counter (
    .clk   (clk),
    .clear (count_clear),
    .enable(count_en),
    .tick  (tick)
  );

  // serial_out is loaded together with each state change so the pin comes straight from a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      serial_out <= UART_IDLE_LEVEL;
      shift_reg  <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          serial_out <= UART_IDLE_LEVEL;
          if (accept) begin
            state      <= START;
            serial_out <= UART_START_BIT;
            shift_reg  <= data_in;
            bit_idx    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end
        START: begin
          if (tick) begin
            state      <= DATA;
            serial_out <= shift_reg[0];
            bit_idx    <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state      <= PARITY;
              serial_out <= parity_bit;
`else
              state      <= STOP;
              serial_out <= UART_STOP_BIT;
`endif
            end else begin
              bit_idx    <= bit_idx + 3'd1;
              shift_reg  <= shift_reg >> 1;
              serial_out <= shift_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state      <= STOP;
            serial_out <= UART_STOP_BIT;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            state      <= IDLE;
            serial_out <= UART_IDLE_LEVEL;
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= UART_IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule
